// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, instruction-memory requester and DEPTH-entry instruction FIFO toward decode.
// Optional macro FETCH_UNIT_PERF_EN adds the 32-bit perf_fetched delivered-instruction counter.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input  logic            CLK,
    input  logic            RST_X,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr
`ifdef FETCH_UNIT_PERF_EN
    ,
    output logic [31:0]     perf_fetched
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [XLEN-1:0] pc_q, pc_d, inflight_pc_q, inflight_pc_d;
    logic            inflight_q, inflight_d;
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW:0]     occ;
    logic            pop, push, issue;
    logic [XLEN-1:0] pc_mem [DEPTH];
    logic [31:0]     instr_mem [DEPTH];
    logic            unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign out_valid = count_q != '0;
    assign pop       = out_valid & out_ready & ~redirect;
    assign push      = inflight_q & ~redirect;
    // Occupancy after this cycle's pop, counting the in-flight slot as reserved (credit rule).
    assign occ       = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign issue     = RST_X & ~redirect & (occ < DEPTH_W);
    assign imem_req  = issue;
    assign imem_addr = pc_q;
    assign out_pc    = pc_mem[rd_q];
    assign out_instr = instr_mem[rd_q];

    // Next-state: redirect wins over issue, push and pop.
    always_comb begin
        pc_d          = redirect ? {redirect_pc[XLEN-1:2], 2'b00} : issue ? pc_q + XLEN'(4) : pc_q;
        inflight_d    = issue;
        inflight_pc_d = issue ? pc_q : inflight_pc_q;
        wr_d          = redirect ? '0 : push ? wr_q + AW'(1) : wr_q;
        rd_d          = redirect ? '0 : pop ? rd_q + AW'(1) : rd_q;
        count_d       = redirect ? '0 : count_q + CW'(push) - CW'(pop);
    end

    // Control state with asynchronous reset.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            wr_q          <= '0;
            rd_q          <= '0;
            count_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            wr_q          <= wr_d;
            rd_q          <= rd_d;
            count_q       <= count_d;
        end
    end

    // FIFO storage: returned word paired with the PC it was fetched from.
    always_ff @(posedge CLK) begin
        if (push) begin
            pc_mem[wr_q]    <= inflight_pc_q;
            instr_mem[wr_q] <= imem_rdata;
        end
    end

`ifdef FETCH_UNIT_PERF_EN
    logic [31:0] perf_q;

    assign perf_fetched = perf_q;

    // Delivered-instruction counter; survives redirects, cleared only by reset.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) perf_q <= '0;
        else if (pop) perf_q <= perf_q + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit (XLEN=32, DEPTH=4, RESET_PC=0).
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST_X = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
`ifdef FETCH_UNIT_PERF_EN
    logic [31:0] perf_fetched;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int reqs     = 0;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(4)) dut (
        .CLK        (CLK),
        .RST_X      (RST_X),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_instr  (out_instr)
`ifdef FETCH_UNIT_PERF_EN
        ,
        .perf_fetched(perf_fetched)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A_1234;
    endfunction

    // Synchronous instruction memory: data for the sampled address one cycle later.
    always @(posedge CLK) imem_rdata <= word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge CLK);
        #2;
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_valid", 32'(out_valid), 0);
`ifdef FETCH_UNIT_PERF_EN
        chk("rst_perf", perf_fetched, 0);
`endif
        RST_X = 1'b1;
        #1;
        chk("first_req", 32'(imem_req), 1);
        chk("first_addr", imem_addr, 0);
        // Streaming from reset, out_ready high
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            #2;
            chk("stream_addr", imem_addr, 32'((i + 1) * 4));
            chk("stream_req", 32'(imem_req), 1);
            if (i == 0) chk("stream_valid0", 32'(out_valid), 0);
            else begin
                chk("stream_valid", 32'(out_valid), 1);
                chk("stream_pc", out_pc, 32'((i - 1) * 4));
                chk("stream_instr", out_instr, word(32'((i - 1) * 4)));
            end
        end
        @(posedge CLK);
        #2;
        chk("pre_redir_pc", out_pc, 32'd36);
`ifdef FETCH_UNIT_PERF_EN
        chk("perf_9", perf_fetched, 9);
`endif
        // Redirect to 0x200 coinciding with out_ready high
        redirect = 1'b1;
        redirect_pc = 32'h200;
        #1;
        chk("redir_noreq", 32'(imem_req), 0);
        @(posedge CLK);
        #2;
        redirect = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("redir_valid", 32'(out_valid), 0);
        chk("redir_addr", imem_addr, 32'h200);
`ifdef FETCH_UNIT_PERF_EN
        chk("perf_no_pop_on_redir", perf_fetched, 9);
`endif
        // Backpressure from empty: exactly DEPTH requests
        reqs = int'(imem_req);
        for (int i = 0; i < 9; i++) begin
            @(posedge CLK);
            #2;
            reqs += int'(imem_req);
        end
        chk("bp_reqs", 32'(reqs), 4);
        chk("bp_req_low", 32'(imem_req), 0);
        chk("bp_valid", 32'(out_valid), 1);
        chk("bp_head_pc", out_pc, 32'h200);
        chk("bp_head_instr", out_instr, word(32'h200));
        chk("bp_addr", imem_addr, 32'h210);
        out_ready = 1'b1;
        #1;
        chk("bp_resume_req", 32'(imem_req), 1);
        // Drain queued entries then continue streaming without a gap
        for (int j = 0; j < 8; j++) begin
            chk("drain_valid", 32'(out_valid), 1);
            chk("drain_pc", out_pc, 32'h200 + 32'(4 * j));
            chk("drain_instr", out_instr, word(32'h200 + 32'(4 * j)));
            @(posedge CLK);
            #2;
        end
        // Redirect to unaligned 0x103 with 3 entries queued and one in flight
        redirect = 1'b1;
        redirect_pc = 32'h103;
        #1;
        chk("redir2_noreq", 32'(imem_req), 0);
`ifdef FETCH_UNIT_PERF_EN
        chk("perf_17", perf_fetched, 17);
`endif
        @(posedge CLK);
        #2;
        redirect = 1'b0;
        #1;
        chk("redir2_valid", 32'(out_valid), 0);
        chk("redir2_addr", imem_addr, 32'h100);
        chk("redir2_req", 32'(imem_req), 1);
`ifdef FETCH_UNIT_PERF_EN
        chk("perf_17_kept", perf_fetched, 17);
`endif
        @(posedge CLK);
        #2;
        chk("redir2_valid_n2", 32'(out_valid), 0);
        chk("redir2_addr_n2", imem_addr, 32'h104);
        @(posedge CLK);
        #2;
        for (int k = 0; k < 5; k++) begin
            chk("redir2_valid_s", 32'(out_valid), 1);
            chk("redir2_pc", out_pc, 32'h100 + 32'(4 * k));
            chk("redir2_instr", out_instr, word(32'h100 + 32'(4 * k)));
            @(posedge CLK);
            #2;
        end
`ifdef FETCH_UNIT_PERF_EN
        chk("perf_22", perf_fetched, 22);
`endif
        // PC wrap at top of address space
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        #1;
        chk("wrap_noreq", 32'(imem_req), 0);
        @(posedge CLK);
        #2;
        redirect = 1'b0;
        #1;
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
        @(posedge CLK);
        #2;
        chk("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
        @(posedge CLK);
        #2;
        chk("wrap_addr2", imem_addr, 32'h0);
        chk("wrap_pc0", out_pc, 32'hFFFF_FFF8);
        @(posedge CLK);
        #2;
        chk("wrap_addr3", imem_addr, 32'h4);
        chk("wrap_pc1", out_pc, 32'hFFFF_FFFC);
        @(posedge CLK);
        #2;
        chk("wrap_pc2", out_pc, 32'h0);
        chk("wrap_instr2", out_instr, word(32'h0));
        // Asynchronous reset mid-stream
        RST_X = 1'b0;
        #1;
        chk("mrst_valid", 32'(out_valid), 0);
        chk("mrst_req", 32'(imem_req), 0);
        chk("mrst_addr", imem_addr, 0);
`ifdef FETCH_UNIT_PERF_EN
        chk("mrst_perf", perf_fetched, 0);
`endif
        @(posedge CLK);
        #2;
        RST_X = 1'b1;
        #1;
        chk("mrst_first_req", 32'(imem_req), 1);
        chk("mrst_first_addr", imem_addr, 0);
        @(posedge CLK);
        #2;
        chk("mrst_valid_n1", 32'(out_valid), 0);
        @(posedge CLK);
        #2;
        chk("mrst_valid_n2", 32'(out_valid), 1);
        chk("mrst_pc", out_pc, 0);
        chk("mrst_instr", out_instr, word(32'h0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
